// File: rtl/dm_pkg.sv
// Shared debug-module types: DMI request/response payloads, DTM opcodes and DTM status codes.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'd0,
    DTM_READ  = 2'd1,
    DTM_WRITE = 2'd2
  } dtm_op_e;

  // Status returned to the host; value 1 is unused by the DTM.
  typedef enum logic [1:0] {
    DTM_SUCCESS = 2'd0,
    DTM_ERR     = 2'd2,
    DTM_BUSY    = 2'd3
  } dtm_op_status_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_initiator.sv
// DTM-side DMI requester: one host command becomes one DMI transaction, with sticky-error,
// busy-on-timeout, dmireset and dmihardreset handling. All outputs come from registers.
module dmi_initiator
  import dm::*;
#(
  parameter int TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_req_valid_i,
  output logic        host_req_ready_o,
  input  logic [1:0]  host_op_i,
  input  logic [6:0]  host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_rsp_valid_o,
  input  logic        host_rsp_ready_i,
  output logic [31:0] host_rsp_data_o,
  output logic [1:0]  host_rsp_status_o,
  input  logic        host_dmireset_i,
  input  logic        host_dmihardreset_i,
  output logic [1:0]  sticky_o,
  output logic        dmi_rst_no,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output dmi_req_t    dmi_req_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  dmi_resp_t   dmi_resp_i
);

  localparam int CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    HOST_RSP,
    DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sticky_q, sticky_d;
  logic                drain_q, drain_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  dmi_req_t            req_q, req_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic [1:0]          rsp_status_q, rsp_status_d;
  logic [31:0]         last_rdata_q, last_rdata_d;
  logic                dmi_rst_nq, dmi_rst_nd;

  logic       sticky_set;
  logic [1:0] sticky_val;
  logic       host_req_fire;

  assign host_req_ready_o  = (state_q == IDLE) && dmi_rst_nq;
  assign host_rsp_valid_o  = (state_q == HOST_RSP);
  assign dmi_req_valid_o   = (state_q == REQ);
  assign dmi_resp_ready_o  = (state_q == WAIT_RSP) || (state_q == DRAIN);
  assign host_rsp_data_o   = rsp_data_q;
  assign host_rsp_status_o = rsp_status_q;
  assign sticky_o          = sticky_q;
  assign dmi_rst_no        = dmi_rst_nq;
  assign dmi_req_o         = req_q;

  assign host_req_fire = host_req_valid_i && host_req_ready_o;

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    last_rdata_d = last_rdata_q;
    sticky_set   = 1'b0;
    sticky_val   = 2'd0;
    dmi_rst_nd   = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (host_req_fire) begin
          if (sticky_q != 2'd0) begin
            rsp_status_d = sticky_q;
            rsp_data_d   = 32'h0;
            state_d      = HOST_RSP;
          end else begin
            unique case (host_op_i)
              2'd0: begin
                rsp_status_d = DTM_SUCCESS;
                rsp_data_d   = last_rdata_q;
                state_d      = HOST_RSP;
              end
              2'd1, 2'd2: begin
                req_d   = '{addr: host_addr_i, op: dtm_op_e'(host_op_i), data: host_wdata_i};
                state_d = REQ;
              end
              default: begin
                rsp_status_d = DTM_ERR;
                rsp_data_d   = 32'h0;
                sticky_set   = 1'b1;
                sticky_val   = DTM_ERR;
                state_d      = HOST_RSP;
              end
            endcase
          end
        end
      end
      REQ: begin
        if (dmi_req_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + CntWidth'(1);
        // A response in the timeout cycle takes precedence over the timeout.
        if (dmi_resp_valid_i) begin
          rsp_data_d   = dmi_resp_i.data;
          rsp_status_d = dmi_resp_i.resp;
          last_rdata_d = dmi_resp_i.data;
          sticky_set   = (dmi_resp_i.resp != 2'd0);
          sticky_val   = dmi_resp_i.resp;
          state_d      = HOST_RSP;
        end else if (cnt_q == CntLast) begin
          rsp_data_d   = 32'h0;
          rsp_status_d = DTM_BUSY;
          sticky_set   = 1'b1;
          sticky_val   = DTM_BUSY;
          drain_d      = 1'b1;
          state_d      = HOST_RSP;
        end
      end
      HOST_RSP: begin
        if (host_rsp_ready_i) begin
          state_d = drain_q ? DRAIN : IDLE;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        if (dmi_resp_valid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    sticky_d = sticky_q;
    if (host_dmireset_i) begin
      sticky_d = 2'd0;
    end
    if (sticky_set && (sticky_q == 2'd0)) begin
      sticky_d = sticky_val;
    end

    if (host_dmihardreset_i) begin
      state_d      = IDLE;
      sticky_d     = 2'd0;
      drain_d      = 1'b0;
      cnt_d        = '0;
      rsp_data_d   = 32'h0;
      rsp_status_d = 2'd0;
      dmi_rst_nd   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sticky_q     <= 2'd0;
      drain_q      <= 1'b0;
      cnt_q        <= '0;
      req_q        <= '0;
      rsp_data_q   <= 32'h0;
      rsp_status_q <= 2'd0;
      last_rdata_q <= 32'h0;
      dmi_rst_nq   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sticky_q     <= sticky_d;
      drain_q      <= drain_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      last_rdata_q <= last_rdata_d;
      dmi_rst_nq   <= dmi_rst_nd;
    end
  end

endmodule

// File: tb/tb_dmi_initiator.sv
// Directed bench for dmi_initiator with a short timeout.
module tb_dmi_initiator;
  import dm::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_req_valid = 1'b0;
  logic        host_req_ready;
  logic [1:0]  host_op = 2'd0;
  logic [6:0]  host_addr = 7'h0;
  logic [31:0] host_wdata = 32'h0;
  logic        host_rsp_valid;
  logic        host_rsp_ready = 1'b0;
  logic [31:0] host_rsp_data;
  logic [1:0]  host_rsp_status;
  logic        dmireset = 1'b0;
  logic        dmihardreset = 1'b0;
  logic [1:0]  sticky;
  logic        dmi_rst_n;
  logic        dmi_req_valid;
  logic        dmi_req_ready = 1'b0;
  dmi_req_t    dmi_req;
  logic        dmi_resp_valid = 1'b0;
  logic        dmi_resp_ready;
  dmi_resp_t   dmi_resp = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [40:0] held_req;

  dmi_initiator #(.TimeoutCycles(4)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .host_req_valid_i    (host_req_valid),
    .host_req_ready_o    (host_req_ready),
    .host_op_i           (host_op),
    .host_addr_i         (host_addr),
    .host_wdata_i        (host_wdata),
    .host_rsp_valid_o    (host_rsp_valid),
    .host_rsp_ready_i    (host_rsp_ready),
    .host_rsp_data_o     (host_rsp_data),
    .host_rsp_status_o   (host_rsp_status),
    .host_dmireset_i     (dmireset),
    .host_dmihardreset_i (dmihardreset),
    .sticky_o            (sticky),
    .dmi_rst_no          (dmi_rst_n),
    .dmi_req_valid_o     (dmi_req_valid),
    .dmi_req_ready_i     (dmi_req_ready),
    .dmi_req_o           (dmi_req),
    .dmi_resp_valid_i    (dmi_resp_valid),
    .dmi_resp_ready_o    (dmi_resp_ready),
    .dmi_resp_i          (dmi_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata);
    host_req_valid = 1'b1;
    host_op        = op;
    host_addr      = addr;
    host_wdata     = wdata;
    tick();
    host_req_valid = 1'b0;
  endtask

  task automatic dm_accept();
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
  endtask

  task automatic dm_respond(input logic [31:0] data, input logic [1:0] resp);
    dmi_resp_valid = 1'b1;
    dmi_resp       = '{data: data, resp: resp};
    tick();
    dmi_resp_valid = 1'b0;
  endtask

  task automatic host_take(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_status);
    check({tag, "_rsp_valid"}, 64'(host_rsp_valid), 64'd1);
    check({tag, "_rsp_data"}, 64'(host_rsp_data), 64'(exp_data));
    check({tag, "_rsp_status"}, 64'(host_rsp_status), 64'(exp_status));
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;
    check({tag, "_rsp_done"}, 64'(host_rsp_valid), 64'd0);
  endtask

  task automatic pulse_dmireset();
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_req_ready", 64'(host_req_ready), 64'd0);
    check("rst_rsp_valid", 64'(host_rsp_valid), 64'd0);
    check("rst_dmi_req_valid", 64'(dmi_req_valid), 64'd0);
    check("rst_dmi_resp_ready", 64'(dmi_resp_ready), 64'd0);
    check("rst_sticky", 64'(sticky), 64'd0);
    check("rst_rsp_data", 64'(host_rsp_data), 64'd0);
    check("rst_rsp_status", 64'(host_rsp_status), 64'd0);
    check("rst_dmi_req", 64'(dmi_req), 64'd0);
    check("rst_dmi_rst_n", 64'(dmi_rst_n), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_dmi_rst_n", 64'(dmi_rst_n), 64'd1);
    check("post_rst_req_ready", 64'(host_req_ready), 64'd1);

    // WRITE 0x10 <- 1, latency 1 to request and 3 to host response
    issue(2'd2, 7'h10, 32'h1);
    check("wr_req_valid", 64'(dmi_req_valid), 64'd1);
    check("wr_req", 64'(dmi_req), {23'h0, 7'h10, 2'd2, 32'h1});
    check("wr_busy_ready", 64'(host_req_ready), 64'd0);
    dm_accept();
    check("wr_wait_resp_ready", 64'(dmi_resp_ready), 64'd1);
    check("wr_wait_req_valid", 64'(dmi_req_valid), 64'd0);
    dm_respond(32'h0, 2'd0);
    host_take("wr", 32'h0, 2'd0);
    check("wr_idle_ready", 64'(host_req_ready), 64'd1);

    // READ 0x11, then NOP returns the captured read data
    issue(2'd1, 7'h11, 32'h0);
    check("rd_req", 64'(dmi_req), {23'h0, 7'h11, 2'd1, 32'h0});
    dm_accept();
    dm_respond(32'h0003_0382, 2'd0);
    host_take("rd", 32'h0003_0382, 2'd0);
    issue(2'd0, 7'h0, 32'h0);
    check("nop_no_req", 64'(dmi_req_valid), 64'd0);
    host_take("nop", 32'h0003_0382, 2'd0);

    // Failed READ sets sticky; next WRITE is refused until dmireset
    issue(2'd1, 7'h12, 32'h0);
    dm_accept();
    dm_respond(32'hDEAD_BEEF, 2'd2);
    check("err_sticky", 64'(sticky), 64'd2);
    host_take("err", 32'hDEAD_BEEF, 2'd2);
    issue(2'd2, 7'h13, 32'h5);
    check("sticky_wr_no_req", 64'(dmi_req_valid), 64'd0);
    host_take("sticky_wr", 32'h0, 2'd2);
    pulse_dmireset();
    check("dmireset_sticky", 64'(sticky), 64'd0);
    issue(2'd2, 7'h13, 32'h5);
    check("after_reset_req_valid", 64'(dmi_req_valid), 64'd1);
    check("after_reset_req", 64'(dmi_req), {23'h0, 7'h13, 2'd2, 32'h5});
    dm_accept();
    dm_respond(32'h0, 2'd0);
    host_take("after_reset", 32'h0, 2'd0);

    // Reserved op 3
    issue(2'd3, 7'h01, 32'h0);
    check("op3_no_req", 64'(dmi_req_valid), 64'd0);
    check("op3_sticky", 64'(sticky), 64'd2);
    host_take("op3", 32'h0, 2'd2);
    pulse_dmireset();
    check("op3_clear", 64'(sticky), 64'd0);

    // Timeout after 4 WAIT_RSP cycles, then late response drained
    issue(2'd1, 7'h20, 32'h0);
    dm_accept();
    for (int i = 0; i < 3; i++) begin
      check("to_waiting", 64'(dmi_resp_ready), 64'd1);
      check("to_no_rsp", 64'(host_rsp_valid), 64'd0);
      tick();
    end
    check("to_last_wait", 64'(dmi_resp_ready), 64'd1);
    tick();
    check("to_sticky", 64'(sticky), 64'd3);
    host_take("to", 32'h0, 2'd3);
    check("drain_resp_ready", 64'(dmi_resp_ready), 64'd1);
    check("drain_req_ready", 64'(host_req_ready), 64'd0);
    tick();
    check("drain_holds", 64'(dmi_resp_ready), 64'd1);
    dm_respond(32'h5555_5555, 2'd0);
    check("drain_idle", 64'(host_req_ready), 64'd1);
    check("drain_sticky", 64'(sticky), 64'd3);
    check("drain_no_rsp", 64'(host_rsp_valid), 64'd0);
    pulse_dmireset();

    // Response in the timeout cycle wins
    issue(2'd1, 7'h21, 32'h0);
    dm_accept();
    tick();
    tick();
    tick();
    dm_respond(32'h1234_5678, 2'd0);
    check("race_sticky", 64'(sticky), 64'd0);
    host_take("race", 32'h1234_5678, 2'd0);
    check("race_no_drain", 64'(host_req_ready), 64'd1);

    // Request stalled 20 cycles: valid and payload held, no timeout
    issue(2'd2, 7'h22, 32'hCAFE_F00D);
    held_req = dmi_req;
    check("stall_req", 64'(held_req), {23'h0, 7'h22, 2'd2, 32'hCAFE_F00D});
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall_valid", 64'(dmi_req_valid), 64'd1);
      check("stall_stable", 64'(dmi_req), 64'(held_req));
    end
    check("stall_no_rsp", 64'(host_rsp_valid), 64'd0);
    dm_accept();
    dm_respond(32'h0, 2'd0);
    host_take("stall", 32'h0, 2'd0);

    // Hardreset during WAIT_RSP, coincident with dmireset
    issue(2'd1, 7'h23, 32'h0);
    dm_accept();
    dmihardreset = 1'b1;
    dmireset     = 1'b1;
    tick();
    dmihardreset = 1'b0;
    dmireset     = 1'b0;
    check("hr_rst_n_low", 64'(dmi_rst_n), 64'd0);
    check("hr_req_ready", 64'(host_req_ready), 64'd0);
    check("hr_rsp_valid", 64'(host_rsp_valid), 64'd0);
    check("hr_resp_ready", 64'(dmi_resp_ready), 64'd0);
    check("hr_sticky", 64'(sticky), 64'd0);
    tick();
    check("hr_rst_n_high", 64'(dmi_rst_n), 64'd1);
    check("hr_idle_ready", 64'(host_req_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("hr_no_rsp", 64'(host_rsp_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
